// File: rtl/kbd_event_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : kbd_event_ctrl_if
// Brief    : PS/2 front-end pop handshake plus event-queue consumer handshake.
// Revision : 1.0
// ============================================================================
interface kbd_event_ctrl_if;
  logic [7:0]  ps2_data;
  logic        ps2_ready;
  logic        ps2_overflow;
  logic        ps2_nextdata_n;
  logic [13:0] ev_data;
  logic        ev_valid;
  logic        ev_ready;

  // master: front end + CPU-side consumer; slave: the sequencing controller
  modport master (
    output ps2_data, ps2_ready, ps2_overflow, ev_ready,
    input  ps2_nextdata_n, ev_data, ev_valid
  );

  modport slave (
    input  ps2_data, ps2_ready, ps2_overflow, ev_ready,
    output ps2_nextdata_n, ev_data, ev_valid
  );
endinterface
`default_nettype wire

// File: rtl/kbd_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kbd_event_ctrl
// Brief    : Folds E0/F0 scan-code prefixes into key events with modifier
//            state and repeat filtering, queued in a fall-through event FIFO.
// Revision : 1.0
// ============================================================================
module kbd_event_ctrl #(
  parameter int FIFO_DEPTH    = 8,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  wire logic                      clk,
  input  wire logic                      clr,
  kbd_event_ctrl_if.slave                bus,
  output logic [3:0]                     mods,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic [7:0]                     drop_cnt
);
  localparam int                c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]     c_full     = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]     c_cnt_zero = '0;
  localparam logic [c_aw-1:0]   c_ptr_one  = (c_aw)'(1);
  localparam logic [7:0]        c_code_ext = 8'hE0;
  localparam logic [7:0]        c_code_brk = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DEC  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cur;
  logic              r_ext_f;
  logic              r_brk_f;
  logic [3:0]        r_mods;
  logic              r_last_valid;
  logic              r_last_ext;
  logic [7:0]        r_last_code;
  logic              r_ovf_q;
  logic [7:0]        r_drop_cnt;
  logic [13:0]       r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;

  logic              w_dec;
  logic              w_prefix;
  logic              w_make;
  logic              w_key_match;
  logic              w_repeat;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;
  logic              w_drop;
  logic              w_ovf_edge;
  logic [3:0]        w_mods_nxt;
  logic [13:0]       w_event;
  logic [1:0]        w_drop_inc;
  logic [8:0]        w_drop_sum;

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus.ps2_nextdata_n = 1'b1;
    case (r_state)
      IDLE:    if (bus.ps2_ready) w_state_nxt = ACK;
      ACK: begin
        bus.ps2_nextdata_n = 1'b0;
        w_state_nxt        = DEC;
      end
      DEC:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr)                              r_cur <= 8'h00;
    else if (r_state == IDLE && bus.ps2_ready) r_cur <= bus.ps2_data;
  end

  // ------------------------------------------------------------- decode ----
  assign w_dec       = (r_state == DEC);
  assign w_prefix    = (r_cur == c_code_ext) || (r_cur == c_code_brk);
  assign w_make      = !r_brk_f;
  assign w_key_match = r_last_valid && (r_last_ext == r_ext_f) && (r_last_code == r_cur);
  assign w_repeat    = FILTER_REPEAT && w_make && w_key_match;
  assign w_push      = w_dec && !w_prefix && !w_repeat;
  assign w_ovf_edge  = bus.ps2_overflow && !r_ovf_q;
  assign w_event     = {w_mods_nxt, r_ext_f, r_brk_f, r_cur};

  // bit order {caps, alt, ctrl, shift}; the extended flag is irrelevant here
  always_comb begin
    w_mods_nxt = r_mods;
    case (r_cur)
      8'h12, 8'h59: w_mods_nxt[0] = w_make;
      8'h14:        w_mods_nxt[1] = w_make;
      8'h11:        w_mods_nxt[2] = w_make;
      8'h58:        if (w_make) w_mods_nxt[3] = !r_mods[3];
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ext_f <= 1'b0;
      r_brk_f <= 1'b0;
      r_mods  <= 4'h0;
      r_ovf_q <= 1'b0;
    end else begin
      r_ovf_q <= bus.ps2_overflow;
      if (w_dec) begin
        if (r_cur == c_code_ext)      r_ext_f <= 1'b1;
        else if (r_cur == c_code_brk) r_brk_f <= 1'b1;
        else begin
          r_ext_f <= 1'b0;
          r_brk_f <= 1'b0;
        end
      end
      if (w_ovf_edge) begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
      end
      if (w_push) r_mods <= w_mods_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_last_valid <= 1'b0;
      r_last_ext   <= 1'b0;
      r_last_code  <= 8'h00;
    end else if (w_push) begin
      if (w_make) begin
        r_last_valid <= 1'b1;
        r_last_ext   <= r_ext_f;
        r_last_code  <= r_cur;
      end else if (w_key_match) begin
        r_last_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------- event FIFO ----
  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == c_cnt_zero);
  assign w_wr    = w_push && !w_full;
  assign w_rd    = !w_empty && bus.ev_ready;
  assign w_drop  = w_push && w_full;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_event;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // a FIFO drop and an overflow edge can land in the same cycle
  assign w_drop_inc = {1'b0, w_drop} + {1'b0, w_ovf_edge};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

  always_ff @(posedge clk) begin
    if (clr) r_drop_cnt <= 8'h00;
    else     r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  assign bus.ev_valid = !w_empty;
  assign bus.ev_data  = w_empty ? 14'h0000 : r_mem[r_rd_ptr];
  assign mods         = r_mods;
  assign fifo_count   = r_count;
  assign drop_cnt     = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_kbd_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_event_ctrl
// Brief    : Directed and randomized scan-code streams against a key-event model.
// Revision : 1.0
// ============================================================================
module tb_kbd_event_ctrl;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  kbd_event_ctrl_if kb();
  kbd_event_ctrl_if kb1();

  logic [3:0] mods, mods1;
  logic [3:0] fc, fc1;
  logic [7:0] drop, drop1;

  kbd_event_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(1'b1)) dut (
    .clk(clk), .clr(clr), .bus(kb), .mods(mods), .fifo_count(fc), .drop_cnt(drop)
  );

  kbd_event_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(1'b0)) dut_nf (
    .clk(clk), .clr(clr), .bus(kb1), .mods(mods1), .fifo_count(fc1), .drop_cnt(drop1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Front ends, consumer log and expected-event queue
  logic [7:0]  fe_q[$];
  logic [7:0]  fe_q1[$];
  logic [13:0] exp_q[$];
  logic [13:0] got_q[$];
  int          pulses  = 0;
  int          ev1_cnt = 0;

  always @(negedge clk) begin
    if (!kb.ps2_nextdata_n) begin
      pulses++;
      if (fe_q.size() != 0) fe_q.delete(0);
    end
    if (!kb1.ps2_nextdata_n && fe_q1.size() != 0) fe_q1.delete(0);
    kb.ps2_ready  = (fe_q.size() != 0);
    kb.ps2_data   = (fe_q.size() != 0) ? fe_q[0] : 8'h00;
    kb1.ps2_ready = (fe_q1.size() != 0);
    kb1.ps2_data  = (fe_q1.size() != 0) ? fe_q1[0] : 8'h00;
    if (kb.ev_valid && kb.ev_ready) begin
      got_q.push_back(kb.ev_data);
      check("event", 32'(kb.ev_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
      if (exp_q.size() != 0) exp_q.delete(0);
    end
    if (kb1.ev_valid && kb1.ev_ready) ev1_cnt++;
  end

  // Key-event reference model: keyboard semantics, not controller cycles
  bit         m_ext, m_brk, m_shift, m_ctrl, m_alt, m_caps, m_have_last;
  logic [8:0] m_last;
  int         m_drop;

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_alt = 0; m_caps = 0;
    m_have_last = 0; m_last = '0; m_drop = 0;
  endfunction

  function automatic logic [3:0] m_mods();
    return {m_caps, m_alt, m_ctrl, m_shift};
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [8:0] key;
    bit         make;
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    key  = {m_ext, b};
    make = !m_brk;
    if (!(make && m_have_last && m_last == key)) begin
      if (b == 8'h12 || b == 8'h59) m_shift = make;
      if (b == 8'h14) m_ctrl = make;
      if (b == 8'h11) m_alt = make;
      if (b == 8'h58 && make) m_caps = !m_caps;
      if (exp_q.size() < DEPTH) exp_q.push_back({m_mods(), m_ext, m_brk, b});
      else if (m_drop < 255) m_drop++;
      if (make) begin m_last = key; m_have_last = 1; end
      else if (m_have_last && m_last == key) m_have_last = 0;
    end
    m_ext = 0;
    m_brk = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    fe_q.push_back(b);
    model_byte(b);
  endtask

  task automatic settle(input bit rand_ready);
    int guard = 0;
    while ((fe_q.size() != 0 || fe_q1.size() != 0) && guard < 400) begin
      if (rand_ready) kb.ev_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    check("fe_timeout", 32'(fe_q.size()), 32'd0);
    repeat (4) tick();
    if (rand_ready) kb.ev_ready = 1'b1;
    if (kb.ev_ready) begin
      guard = 0;
      while (kb.ev_valid && guard < 100) begin tick(); guard++; end
      tick();
      check("events_missing", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic ovf_pulse();
    kb.ps2_overflow = 1'b1;
    tick(); tick();
    kb.ps2_overflow = 1'b0;
    tick();
    m_ext = 0;
    m_brk = 0;
    if (m_drop < 255) m_drop++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(kb.ev_valid), 32'd0);
    check({tag, "_data"},  32'(kb.ev_data), 32'd0);
    check({tag, "_count"}, 32'(fc), 32'd0);
    check({tag, "_mods"},  32'(mods), 32'd0);
    check({tag, "_drop"},  32'(drop), 32'd0);
    check({tag, "_popn"},  32'(kb.ps2_nextdata_n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [13] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58,
                              8'h1C, 8'h1C, 8'h1B, 8'h23, 8'hE0, 8'hF0};
    logic [7:0] codes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                               8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    int g0, p0, e1;

    clr = 1'b1;
    kb.ps2_overflow = 1'b0; kb.ev_ready = 1'b1;
    kb1.ps2_overflow = 1'b0; kb1.ev_ready = 1'b1;
    model_reset();
    repeat (3) tick();
    clr = 1'b0;
    tick();
    check_reset_state("rst");

    // make then break of 1C, with first-event latency
    g0 = got_q.size(); p0 = pulses;
    send(8'h1C);
    tick(); tick();
    check("lat_t2_valid", 32'(kb.ev_valid), 32'd0);
    tick();
    check("lat_t3_valid", 32'(kb.ev_valid), 32'd1);
    send(8'hF0); send(8'h1C);
    settle(1'b0);
    check("t1_n",    32'(got_q.size() - g0), 32'd2);
    check("t1_ev0",  32'(got_q[g0]), 32'h01C);
    check("t1_ev1",  32'(got_q[g0+1]), 32'h11C);
    check("t1_pops", 32'(pulses - p0), 32'd3);

    // typematic repeats, filter on vs off
    g0 = got_q.size(); e1 = ev1_cnt;
    foreach (pool[i]) if (i < 0) send(pool[i]);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    fe_q1.push_back(8'h1C); fe_q1.push_back(8'h1C); fe_q1.push_back(8'h1C);
    fe_q1.push_back(8'hF0); fe_q1.push_back(8'h1C);
    settle(1'b0);
    check("rep_filter_on",  32'(got_q.size() - g0), 32'd2);
    check("rep_filter_off", 32'(ev1_cnt - e1), 32'd4);

    // shift held across a key
    g0 = got_q.size();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
    settle(1'b0);
    check("t2_ev0", 32'(got_q[g0]),   32'h412);
    check("t2_ev1", 32'(got_q[g0+1]), 32'h41C);
    check("t2_ev2", 32'(got_q[g0+2]), 32'h112);
    check("t2_mods", 32'(mods), 32'h0);

    // right ctrl make/break (extended)
    g0 = got_q.size();
    send(8'hE0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
    settle(1'b0);
    check("t3_ev0", 32'(got_q[g0]),   32'hA14);
    check("t3_ev1", 32'(got_q[g0+1]), 32'h314);

    // caps lock toggles on make only
    g0 = got_q.size();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    settle(1'b0);
    check("t4_ev",   32'(got_q[got_q.size()-1]), 32'h201C);
    check("t4_mods", 32'(mods), 32'h8);

    // randomized bursts with a stalling consumer and overflow edges
    for (int b = 0; b < 25; b++) begin
      int n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) send(pool[$urandom_range(0, 12)]);
      settle(1'b1);
      check("rand_mods", 32'(mods), 32'(m_mods()));
      if ($urandom_range(0, 3) == 0) ovf_pulse();
      check("rand_drop", 32'(drop), 32'(m_drop));
    end
    send(8'hF0); send(8'h1C);
    settle(1'b0);

    // fill past capacity with the consumer stalled
    kb.ev_ready = 1'b0;
    foreach (codes[i]) send(codes[i]);
    settle(1'b0);
    check("full_count", 32'(fc), 32'd8);
    check("full_drop",  32'(drop), 32'(m_drop));
    check("full_valid", 32'(kb.ev_valid), 32'd1);
    kb.ev_ready = 1'b1;
    settle(1'b0);
    check("drain_count", 32'(fc), 32'd0);

    // drop counter saturation
    repeat (260) ovf_pulse();
    check("drop_sat", 32'(drop), 32'd255);

    // reset with queued events
    kb.ev_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24);
    settle(1'b0);
    check("pre_rst_count", 32'(fc), 32'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    model_reset();
    check_reset_state("rst2");

    kb.ev_ready = 1'b1;
    g0 = got_q.size();
    send(8'h1C);
    settle(1'b0);
    check("post_rst_ev", 32'(got_q[g0]), 32'h01C);
    check("nf_drop",  32'(drop1), 32'd0);
    check("nf_count", 32'(fc1), 32'd0);
    check("nf_mods",  32'(mods1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
